wb_master_ctrl: RTL and testbench



---
 rtl/wb_master_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_wb_master_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl
//   WISHBONE master and slave decoder sitting between the CPU data-memory
//   port and up to 15 slaves. One core access is handled at a time. The
//   target slave comes from a region map indexed by the top RB address
//   bits. The core is stalled with pause until the slave acks, errors or
//   the access times out. Read data is held until the next read completion.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req/we/addr/wdata/be
//                     core access, held by the core while pause is high
//   pause             stall to core
//   rdata             registered read data (all-ones on a failed read)
//   err               access failed, valid in the DONE cycle
//   err_addr          address of the last failed access
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_dat_o/wb_sel_o
//                     WISHBONE master outputs; stb is one-hot per slave
//   wb_dat_i/wb_ack_i/wb_err_i
//                     per-slave return paths; slave i data at [DW*i +: DW]
module wb_master_ctrl #(
   parameter int unsigned          NSLV    = 9,
   parameter int unsigned          AW      = 32,
   parameter int unsigned          DW      = 32,
   parameter int unsigned          RB      = 4,
   parameter logic [4*(2**RB)-1:0] MAP     = 64'h8765_4321_0000_0000,
   parameter int unsigned          TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 we,
   input  logic [AW-1:0]        addr,
   input  logic [DW-1:0]        wdata,
   input  logic [DW/8-1:0]      be,
   output logic                 pause,
   output logic [DW-1:0]        rdata,
   output logic                 err,
   output logic [AW-1:0]        err_addr,
   output logic                 wb_cyc_o,
   output logic [NSLV-1:0]      wb_stb_o,
   output logic                 wb_we_o,
   output logic [AW-1:0]        wb_adr_o,
   output logic [DW-1:0]        wb_dat_o,
   output logic [DW/8-1:0]      wb_sel_o,
   input  logic [NSLV*DW-1:0]   wb_dat_i,
   input  logic [NSLV-1:0]      wb_ack_i,
   input  logic [NSLV-1:0]      wb_err_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_DONE
   } state_t;

   localparam logic        TO_EN   = (TIMEOUT != 0);
   localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;
   localparam logic [4:0]  NSLV5   = 5'(NSLV);

   state_t              state, state_nx;
   logic [15:0]         cnt;

   logic                lat_we;
   logic [AW-1:0]       lat_addr;
   logic [DW-1:0]       lat_wdata;
   logic [DW/8-1:0]     lat_be;
   logic [3:0]          lat_idx;

   logic [3:0]          dec_idx;
   logic                dec_ok;
   logic                sel_ack;
   logic                sel_err;
   logic [DW-1:0]       sel_dat;
   logic                timeout_hit;

   // Region decode of the live core address (only used in IDLE).
   always_comb begin
      dec_idx = MAP[{addr[AW-1 -: RB], 2'b00} +: 4];
      dec_ok  = (dec_idx != 4'hF) && ({1'b0, dec_idx} < NSLV5);
   end

   // Only the latched slave's ack/err/data are looked at.
   always_comb begin
      sel_ack  = 1'b0;
      sel_err  = 1'b0;
      sel_dat  = '0;
      wb_stb_o = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (lat_idx == 4'(i)) begin
            sel_ack     = wb_ack_i[i];
            sel_err     = wb_err_i[i];
            sel_dat     = wb_dat_i[DW*i +: DW];
            wb_stb_o[i] = (state == S_BUS);
         end
      end
   end

   // Timeout fires only in a cycle with neither ack nor err.
   always_comb begin
      timeout_hit = TO_EN && (cnt == TO_LAST) && !sel_ack && !sel_err;
   end

   // Bus outputs are driven from registers only, never from core inputs.
   always_comb begin
      wb_cyc_o = (state == S_BUS);
      wb_we_o  = lat_we;
      wb_adr_o = lat_addr;
      wb_dat_o = lat_wdata;
      wb_sel_o = lat_be;
   end

   // Next-state and stall.
   always_comb begin
      state_nx = state;
      pause    = 1'b0;
      unique case (state)
         S_IDLE: begin
            pause = req;
            if (req) begin
               state_nx = dec_ok ? S_BUS : S_DONE;
            end
         end
         S_BUS: begin
            pause = 1'b1;
            if (sel_err || sel_ack || timeout_hit) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         lat_idx   <= '0;
         rdata     <= '0;
         err       <= 1'b0;
         err_addr  <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            S_IDLE: begin
               err <= 1'b0;
               if (req) begin
                  lat_we    <= we;
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  lat_be    <= be;
                  lat_idx   <= dec_idx;
                  cnt       <= '0;
                  // Unmapped: complete straight away as an error, no bus cycle.
                  if (!dec_ok) begin
                     err      <= 1'b1;
                     err_addr <= addr;
                     if (!we) begin
                        rdata <= '1;
                     end
                  end
               end
            end
            S_BUS: begin
               if (sel_err || timeout_hit) begin
                  err      <= 1'b1;
                  err_addr <= lat_addr;
                  if (!lat_we) begin
                     rdata <= '1;
                  end
               end else if (sel_ack) begin
                  if (!lat_we) begin
                     rdata <= sel_dat;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DONE: begin
               err <= 1'b0;
            end
            default: begin
               err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Self-checking bench for wb_master_ctrl: directed cases followed by random
// accesses, each checked against a cycle-level model of the expected access
// (decode table, number of bus cycles, completion outcome).
module tb_wb_master_ctrl;

   localparam int NS = 9;
   localparam int TO = 4;

   logic               clk;
   logic               rst;
   logic               req;
   logic               we;
   logic [31:0]        addr;
   logic [31:0]        wdata;
   logic [3:0]         be;
   logic               pause;
   logic [31:0]        rdata;
   logic               err;
   logic [31:0]        err_addr;
   logic               wb_cyc_o;
   logic [NS-1:0]      wb_stb_o;
   logic               wb_we_o;
   logic [31:0]        wb_adr_o;
   logic [31:0]        wb_dat_o;
   logic [3:0]         wb_sel_o;
   logic [NS*32-1:0]   wb_dat_i;
   logic [NS-1:0]      wb_ack_i;
   logic [NS-1:0]      wb_err_i;

   wb_master_ctrl #(
      .NSLV(NS), .AW(32), .DW(32), .RB(4),
      .MAP(64'h8765_43F1_0000_0000), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .pause(pause), .rdata(rdata), .err(err), .err_addr(err_addr),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // Slave response kinds.
   localparam int K_ACK  = 0;
   localparam int K_ERR  = 1;
   localparam int K_BOTH = 2;
   localparam int K_NONE = 3;

   // Region -> slave table for the map used above (15 = unmapped).
   int          exp_map [16] = '{0,0,0,0,0,0,0,0,1,15,3,4,5,6,7,8};
   logic [31:0] exp_rdata;
   logic [31:0] exp_err_addr;
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Random data and noise ack/err on every slave; the slave 'sel' gets the
   // given response instead.
   task automatic set_slaves(input int sel, input logic a, input logic e, input logic [31:0] d);
      for (int i = 0; i < NS; i++) begin
         if (i == sel) begin
            wb_ack_i[i] = a;
            wb_err_i[i] = e;
            wb_dat_i[32*i +: 32] = d;
         end else begin
            wb_ack_i[i] = 1'($urandom_range(0, 1));
            wb_err_i[i] = 1'($urandom_range(0, 1));
            wb_dat_i[32*i +: 32] = $urandom;
         end
      end
   endtask

   // One complete access. Entered with the DUT idle; returns at the
   // negedge of the DONE cycle with req dropped.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input int waits, input int kind,
                         input logic [31:0] rd, input logic hold);
      int          idx;
      int          nb;
      logic        mapped;
      logic        fail_exp;
      logic        ra;
      logic        re;
      logic [8:0]  stb_exp;
      idx      = exp_map[a[31:28]];
      mapped   = (idx != 15) && (idx < NS);
      nb       = !mapped ? 0 : ((kind == K_NONE) ? TO : waits + 1);
      fail_exp = !mapped || (kind != K_ACK);
      ra       = (kind == K_ACK) || (kind == K_BOTH);
      re       = (kind == K_ERR) || (kind == K_BOTH);
      stb_exp  = mapped ? (9'd1 << idx) : 9'd0;

      @(negedge clk);
      chk("idle_pause_noreq", pause, 0);
      chk("idle_err", err, 0);
      chk("idle_rdata_hold", rdata, exp_rdata);
      set_slaves(idx, 1'b0, 1'b0, $urandom);
      req = 1'b1; we = w; addr = a; wdata = wd; be = b;
      #1;
      chk("idle_pause_req", pause, 1);
      chk("idle_cyc", wb_cyc_o, 0);

      for (int k = 0; k < nb; k++) begin
         @(negedge clk);
         chk("bus_cyc", wb_cyc_o, 1);
         chk("bus_stb", wb_stb_o, stb_exp);
         chk("bus_adr", wb_adr_o, a);
         chk("bus_we", wb_we_o, w);
         chk("bus_dat", wb_dat_o, wd);
         chk("bus_sel", wb_sel_o, b);
         chk("bus_pause", pause, 1);
         chk("bus_err", err, 0);
         chk("bus_rdata_hold", rdata, exp_rdata);
         if (k == waits && kind != K_NONE) set_slaves(idx, ra, re, rd);
         else                              set_slaves(idx, 1'b0, 1'b0, $urandom);
      end

      if (fail_exp) begin
         exp_err_addr = a;
         if (!w) exp_rdata = 32'hFFFF_FFFF;
      end else if (!w) begin
         exp_rdata = rd;
      end

      @(negedge clk);
      chk("done_pause", pause, 0);
      chk("done_cyc", wb_cyc_o, 0);
      chk("done_stb", wb_stb_o, 0);
      chk("done_err", err, fail_exp);
      chk("done_rdata", rdata, exp_rdata);
      chk("done_err_addr", err_addr, exp_err_addr);
      // With hold set, the response stays up through DONE and must be ignored.
      if (!hold) set_slaves(-1, 1'b0, 1'b0, 32'd0);
      req = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      wb_ack_i = '0; wb_err_i = '0; wb_dat_i = '0;
      exp_rdata = '0; exp_err_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_err_addr", err_addr, 0);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_pause", pause, 0);
      rst = 1'b1;

      // Read from slave 1 with two wait states.
      access(1'b0, 32'h8000_0010, 32'h0, 4'hF, 2, K_ACK, 32'h1234_5678, 1'b0);
      // Zero-wait write to slave 0; response held into DONE.
      access(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'b0011, 0, K_ACK, 32'hDEAD_BEEF, 1'b1);
      // Timeout read of slave 8.
      access(1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, K_NONE, 32'h0, 1'b0);
      // Read of slave 1 that completes on the last cycle before timeout.
      access(1'b0, 32'h8000_0020, 32'h0, 4'hF, TO-1, K_ACK, 32'h0BAD_F00D, 1'b0);
      // Simultaneous ack and err on slave 3.
      access(1'b0, 32'hA000_0004, 32'h0, 4'hF, 1, K_BOTH, 32'h1111_2222, 1'b0);
      // Unmapped region 9.
      access(1'b0, 32'h9000_0000, 32'h0, 4'hF, 0, K_ACK, 32'h0, 1'b0);
      // Successful read so rdata is non-zero, then a slave-error write.
      access(1'b0, 32'hB000_0008, 32'h0, 4'hF, 0, K_ACK, 32'h5A5A_0FF0, 1'b0);
      access(1'b1, 32'hC000_000C, 32'h7777_0000, 4'b1100, 2, K_ERR, 32'h0, 1'b0);

      // Reset in the second BUS cycle with req held throughout.
      @(negedge clk);
      set_slaves(1, 1'b0, 1'b0, 32'h0);
      req = 1'b1; we = 1'b0; addr = 32'h8000_0040; wdata = '0; be = 4'hF;
      @(negedge clk);
      chk("rmb_bus0_cyc", wb_cyc_o, 1);
      @(negedge clk);
      chk("rmb_bus1_cyc", wb_cyc_o, 1);
      rst = 1'b0;
      @(negedge clk);
      exp_rdata = '0; exp_err_addr = '0;
      chk("rmb_cyc", wb_cyc_o, 0);
      chk("rmb_stb", wb_stb_o, 0);
      chk("rmb_rdata", rdata, 0);
      chk("rmb_err", err, 0);
      chk("rmb_err_addr", err_addr, 0);
      chk("rmb_pause_req", pause, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rmb_fresh_cyc", wb_cyc_o, 1);
      chk("rmb_fresh_stb", wb_stb_o, 9'b0_0000_0010);
      set_slaves(1, 1'b1, 1'b0, 32'hCAFE_0001);
      exp_rdata = 32'hCAFE_0001;
      @(negedge clk);
      chk("rmb_fresh_rdata", rdata, exp_rdata);
      chk("rmb_fresh_err", err, 0);
      chk("rmb_fresh_pause", pause, 0);
      req = 1'b0;
      set_slaves(-1, 1'b0, 1'b0, 32'h0);

      // Random accesses.
      for (int n = 0; n < 60; n++) begin
         int          r;
         int          kind;
         r = $urandom_range(0, 9);
         kind = (r < 6) ? K_ACK : (r == 6) ? K_ERR : (r == 7) ? K_BOTH : K_NONE;
         access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, TO-1), kind, $urandom, 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      chk("final_rdata_hold", rdata, exp_rdata);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
